// File: rtl/data_cache_pkg.sv
// Shared types and sizing helpers for the data cache.
// Provides the controller state enum, the counter width, and functions
// that derive the index and tag field widths from the geometry.
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    BYPASS = 2'd2
  } cache_state_t;

  localparam int CNT_WIDTH = 32;

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Two low address bits select the byte within the one-word line.
  function automatic int tag_bits(input int addr_width, input int sets);
    return addr_width - $clog2(sets) - 2;
  endfunction

endpackage

// File: rtl/data_cache_line_array.sv
// Line storage for the direct-mapped cache: one valid bit, tag and
// data word per set.
// Ports:
//   clk, rst            clock, async active-high reset (valid bits only)
//   flush               clear every valid bit at the edge
//   index               set addressed for both read and write
//   rd_valid/tag/data   combinational read of the addressed set
//   fill                write wr_tag and set valid for the addressed set
//   be                  byte-lane enables for the data word
//   wr_tag, wr_data     write values
module cache_line_array #(
  parameter int SETS       = 8,
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 27,
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [INDEX_BITS-1:0] index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  fill,
  input  logic [LANES-1:0]      be,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [SETS-1:0]       valid;
  logic [TAG_BITS-1:0]   tags [SETS];
  logic [DATA_WIDTH-1:0] data [SETS];

  // Flush wins over a same-cycle fill so an aborted refill never revalidates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid        <= '0;
    else if (flush) valid        <= '0;
    else if (fill)  valid[index] <= 1'b1;
  end

  // Tag and data need no reset: they are meaningless while valid is clear.
  always_ff @(posedge clk) begin
    if (fill) tags[index] <= wr_tag;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) data[index][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  assign rd_valid = valid[index];
  assign rd_tag   = tags[index];
  assign rd_data  = data[index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, read-allocate data cache in front of
// DataMemory. Loads hit in zero cycles, cacheable misses refill one word
// over two stall cycles, misaligned word loads bypass the array.
// Ports:
//   clk, rst                  clock, async active-high reset
//   cpu_req/we/addr_mode      CPU access strobe, store flag, byte/word mode
//   cpu_addr, cpu_wd          byte address, store data
//   flush                     invalidate all lines
//   cpu_rd, stall             load data (zero-extended bytes), busy flag
//   mem_we/addr_mode/a/wd     DataMemory write/read port
//   mem_rd                    DataMemory combinational read data
//   hit_count, miss_count     saturating performance counters
module data_cache
  import data_cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SETS          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic                     addr_mode,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wd,
  input  logic                     flush,
  output logic [DATA_WIDTH-1:0]    cpu_rd,
  output logic                     stall,
  output logic                     mem_we,
  output logic                     mem_addr_mode,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd,
  output logic [CNT_WIDTH-1:0]     hit_count,
  output logic [CNT_WIDTH-1:0]     miss_count
);

  localparam int INDEX_BITS = index_bits(SETS);
  localparam int TAG_BITS   = tag_bits(ADDRESS_WIDTH, SETS);
  localparam int LANES      = DATA_WIDTH / 8;

  cache_state_t state, state_next;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  hit, cacheable;
  logic [7:0]            lane_byte;
  logic                  fill;
  logic [LANES-1:0]      be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  hit_inc, miss_inc;

  assign offset    = cpu_addr[1:0];
  assign index     = cpu_addr[INDEX_BITS+1:2];
  assign tag       = cpu_addr[ADDRESS_WIDTH-1:INDEX_BITS+2];
  assign hit       = line_valid && (line_tag == tag);
  assign cacheable = addr_mode || (offset == 2'b00);
  assign lane_byte = line_data[{offset, 3'b000} +: 8];

  cache_line_array #(
    .SETS       (SETS),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .index    (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .fill     (fill),
    .be       (be),
    .wr_tag   (tag),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    stall         = 1'b0;
    cpu_rd        = '0;
    mem_we        = 1'b0;
    mem_a         = cpu_addr;
    mem_wd        = cpu_wd;
    mem_addr_mode = addr_mode;
    fill          = 1'b0;
    be            = '0;
    wr_data       = cpu_wd;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    // Reset drives the CPU-facing outputs quiet immediately, not just at the next edge.
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (cpu_req && cpu_we) begin
            mem_we = 1'b1;
            if (hit && cacheable) begin
              if (addr_mode) begin
                be[offset] = 1'b1;
                wr_data    = {LANES{cpu_wd[7:0]}};
              end else begin
                be = '1;
              end
            end
          end else if (cpu_req) begin
            if (!cacheable) begin
              stall      = 1'b1;
              state_next = BYPASS;
            end else if (hit) begin
              cpu_rd  = addr_mode ? DATA_WIDTH'(lane_byte) : line_data;
              hit_inc = 1'b1;
            end else begin
              stall      = 1'b1;
              miss_inc   = 1'b1;
              state_next = REFILL;
            end
          end
        end
        REFILL: begin
          mem_a         = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
          mem_addr_mode = 1'b0;
          stall         = 1'b1;
          state_next    = IDLE;
          if (!flush) begin
            fill    = 1'b1;
            be      = '1;
            wr_data = mem_rd;
          end
        end
        BYPASS: begin
          mem_addr_mode = 1'b0;
          cpu_rd        = mem_rd;
          state_next    = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc  && (hit_count  != '1)) hit_count  <= hit_count + 1'b1;
      if (miss_inc && (miss_count != '1)) miss_count <= miss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic        addr_mode = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wd = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] cpu_rd;
  logic        stall;
  logic        mem_we;
  logic        mem_addr_mode;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_cache #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SETS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .addr_mode     (addr_mode),
    .cpu_addr      (cpu_addr),
    .cpu_wd        (cpu_wd),
    .flush         (flush),
    .cpu_rd        (cpu_rd),
    .stall         (stall),
    .mem_we        (mem_we),
    .mem_addr_mode (mem_addr_mode),
    .mem_a         (mem_a),
    .mem_wd        (mem_wd),
    .mem_rd        (mem_rd),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  // DataMemory model: 256 bytes at 0x10000, little-endian, byte-granular.
  logic [7:0] dmem [0:255];
  logic [7:0] ma0, ma1, ma2, ma3;

  always_comb begin
    ma0 = mem_a[7:0];
    ma1 = mem_a[7:0] + 8'd1;
    ma2 = mem_a[7:0] + 8'd2;
    ma3 = mem_a[7:0] + 8'd3;
    if (mem_addr_mode) mem_rd = {24'h0, dmem[ma0]};
    else               mem_rd = {dmem[ma3], dmem[ma2], dmem[ma1], dmem[ma0]};
  end

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr_mode) begin
        dmem[ma0] <= mem_wd[7:0];
      end else begin
        dmem[ma0] <= mem_wd[7:0];
        dmem[ma1] <= mem_wd[15:8];
        dmem[ma2] <= mem_wd[23:16];
        dmem[ma3] <= mem_wd[31:24];
      end
    end
  end

  task automatic preload();
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    dmem[0] = 8'h11; dmem[1] = 8'h22; dmem[2] = 8'h33; dmem[3] = 8'h44; dmem[4] = 8'h55;
  endtask

  task automatic drive(input logic req, input logic we, input logic mode,
                       input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    cpu_req = req; cpu_we = we; addr_mode = mode; cpu_addr = a; cpu_wd = wd;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    cpu_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (stall !== 1'b0)      begin errors++; $display("FAIL rst_stall got %0b want 0", stall); end
    checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL rst_mem_we got %0b want 0", mem_we); end
    checks++; if (cpu_rd !== 32'h0)    begin errors++; $display("FAIL rst_cpu_rd got %h want 0", cpu_rd); end
    checks++; if (hit_count !== 32'h0) begin errors++; $display("FAIL rst_hit got %0d want 0", hit_count); end
    checks++; if (miss_count !== 32'h0) begin errors++; $display("FAIL rst_miss got %0d want 0", miss_count); end
    @(posedge clk); #1; rst = 1'b0;
    // Idle store-mode inputs without cpu_req must not write memory.
    drive(1'b0, 1'b1, 1'b0, 32'h10000, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_mem_we got %0b want 0", mem_we); end
    checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL idle_stall got %0b want 0", stall); end
  endtask

  task automatic test_miss_hit();
    drive(1'b1, 1'b0, 1'b0, 32'h10000, 32'h0);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL miss_stall1 got %0b want 1", stall); end
    checks++; if (cpu_rd !== 32'h0) begin errors++; $display("FAIL miss_rd_zero got %h want 0", cpu_rd); end
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL miss_stall2 got %0b want 1", stall); end
    checks++; if (mem_a !== 32'h10000) begin errors++; $display("FAIL refill_addr got %h want 00010000", mem_a); end
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL miss_done_stall got %0b want 0", stall); end
    checks++; if (cpu_rd !== 32'h44332211) begin errors++; $display("FAIL miss_data got %h want 44332211", cpu_rd); end
    checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL miss_count1 got %0d want 1", miss_count); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hit_stall got %0b want 0", stall); end
    checks++; if (cpu_rd !== 32'h44332211) begin errors++; $display("FAIL hit_data got %h want 44332211", cpu_rd); end
    checks++; if (hit_count !== 32'd1) begin errors++; $display("FAIL hit_count1 got %0d want 1", hit_count); end
  endtask

  task automatic test_byte_load();
    drive(1'b1, 1'b0, 1'b1, 32'h10002, 32'h0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bload_stall got %0b want 0", stall); end
    checks++; if (cpu_rd !== 32'h00000033) begin errors++; $display("FAIL bload_data got %h want 00000033", cpu_rd); end
    checks++; if (hit_count !== 32'd2) begin errors++; $display("FAIL bload_hits got %0d want 2", hit_count); end
  endtask

  task automatic test_byte_store();
    drive(1'b1, 1'b1, 1'b1, 32'h10001, 32'h000000AA);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL bstore_we got %0b want 1", mem_we); end
    checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL bstore_stall got %0b want 0", stall); end
    checks++; if (mem_a !== 32'h10001 || mem_addr_mode !== 1'b1)
      begin errors++; $display("FAIL bstore_port got a=%h mode=%0b want a=00010001 mode=1", mem_a, mem_addr_mode); end
    drive(1'b1, 1'b0, 1'b0, 32'h10000, 32'h0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bstore_rd_stall got %0b want 0", stall); end
    checks++; if (cpu_rd !== 32'h4433AA11) begin errors++; $display("FAIL bstore_line got %h want 4433aa11", cpu_rd); end
    checks++; if ({dmem[3], dmem[2], dmem[1], dmem[0]} !== 32'h4433AA11)
      begin errors++; $display("FAIL bstore_mem got %h want 4433aa11", {dmem[3], dmem[2], dmem[1], dmem[0]}); end
    checks++; if (hit_count !== 32'd3) begin errors++; $display("FAIL bstore_hits got %0d want 3", hit_count); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_conflict();
    logic [31:0] addrs [3];
    logic [31:0] exp_rd [3];
    addrs[0] = 32'h10000; exp_rd[0] = 32'h4433AA11;
    addrs[1] = 32'h10020; exp_rd[1] = 32'h00000000;
    addrs[2] = 32'h10000; exp_rd[2] = 32'h4433AA11;
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, addrs[i], 32'h0);
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL conflict_miss[%0d] got %0b want 1", i, stall); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (cpu_rd !== exp_rd[i]) begin errors++; $display("FAIL conflict_data[%0d] got %h want %h", i, cpu_rd, exp_rd[i]); end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (miss_count !== 32'd3) begin errors++; $display("FAIL conflict_misses got %0d want 3", miss_count); end
    checks++; if (hit_count !== 32'd3)  begin errors++; $display("FAIL conflict_hits got %0d want 3", hit_count); end
  endtask

  task automatic test_misaligned();
    @(posedge clk); #1;
    preload();
    drive(1'b1, 1'b0, 1'b0, 32'h10001, 32'h0);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bypass_stall1 got %0b want 1", stall); end
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bypass_stall2 got %0b want 0", stall); end
    checks++; if (cpu_rd !== 32'h55443322) begin errors++; $display("FAIL bypass_data got %h want 55443322", cpu_rd); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (miss_count !== 32'd3 || hit_count !== 32'd3)
      begin errors++; $display("FAIL bypass_counters got h=%0d m=%0d want h=3 m=3", hit_count, miss_count); end
  endtask

  task automatic test_flush_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h10020, 32'h0);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_miss got %0b want 1", stall); end
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_refill_stall got %0b want 1", stall); end
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_remiss got %0b want 1", stall); end
    checks++; if (miss_count !== 32'd4) begin errors++; $display("FAIL flush_misses got %0d want 4", miss_count); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (stall !== 1'b0 || miss_count !== 32'd5)
      begin errors++; $display("FAIL flush_recover got stall=%0b m=%0d want stall=0 m=5", stall, miss_count); end
    drive(1'b1, 1'b0, 1'b0, 32'h10000, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_refill_pre got %0b want 1", stall); end
    #1 rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_refill_stall got %0b want 0", stall); end
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0)
      begin errors++; $display("FAIL rst_refill_cnt got h=%0d m=%0d want 0 0", hit_count, miss_count); end
    cpu_req = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h10000, 32'h0);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_no_fill got %0b want 1", stall); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (cpu_rd !== 32'h44332211) begin errors++; $display("FAIL rst_reload got %h want 44332211", cpu_rd); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    preload();
    test_reset();
    test_miss_hit();
    test_byte_load();
    test_byte_store();
    test_conflict();
    test_misaligned();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, read-allocate data cache between the CPU's memory-access stage and `DataMemory`. It serves word and byte loads from a small line array and stalls the pipeline for a fixed two-cycle refill on a miss. Stores write through to `DataMemory` in the same cycle. The unit also keeps hit/miss performance counters. `DataMemory` remains the backing store and is unmodified; its combinational read feeds `mem_rd`.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, word width; line = one word.
- `SETS`, 8, number of lines; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_req`  in  1  access valid this cycle; held stable while `stall`=1.
- `cpu_we`  in  1  1 = store, 0 = load.
- `addr_mode`  in  1  1 = byte access, 0 = word access (same encoding as `DataMemory`).
- `cpu_addr`  in  ADDRESS_WIDTH  byte address.
- `cpu_wd`  in  DATA_WIDTH  store data; byte store uses [7:0].
- `flush`  in  1  invalidate all lines.
- `cpu_rd`  out  DATA_WIDTH  load data; byte loads zero-extended.
- `stall`  out  1  access not complete this cycle.
- `mem_we`, `mem_addr_mode`  out  1  to `DataMemory` `WE` / `addr_mode`.
- `mem_a`  out  ADDRESS_WIDTH  to `DataMemory` `A`.
- `mem_wd`  out  DATA_WIDTH  to `DataMemory` `WD`.
- `mem_rd`  in  DATA_WIDTH  from `DataMemory` `RD`, combinational.
- `hit_count`, `miss_count`  out  32  saturating counters.

## Operation
Address split:
- offset = `cpu_addr`[1:0]
- index = `cpu_addr`[log2(SETS)+1:2]
- tag = remaining upper bits

Hit = `valid[index]` && `tag_array[index]` == tag.

Cacheable accesses:
- Byte accesses at any offset.
- Word accesses with offset = 0.
- A word load with offset ≠ 0 is uncached (BYPASS).

States: IDLE, REFILL, BYPASS.
- **IDLE, load hit:** `cpu_rd` = line word, or the selected byte lane zero-extended. `stall`=0. `hit_count`++.
- **IDLE, cacheable load miss:** `stall`=1. `miss_count`++. Next state REFILL.
- **IDLE, misaligned word load:** `stall`=1. Next state BYPASS.
- **IDLE, store (any):**
  - `mem_we`=1; `mem_a`/`mem_wd`/`mem_addr_mode` pass through from the CPU side.
  - `stall`=0.
  - On hit, the written bytes are updated in the line: word, or the single lane at offset. A misaligned word store is never a hit.
  - On miss, no allocation.
  - No counter changes.
- **REFILL:**
  - `mem_a` = {`cpu_addr`[ADDRESS_WIDTH-1:2], 2'b00}, `mem_addr_mode`=0, `mem_we`=0, `stall`=1.
  - At the edge: data ← `mem_rd`, tag written, valid set. Next state IDLE.
  - The held request then hits.
- **BYPASS:** `mem_a` = `cpu_addr`, `mem_addr_mode`=0, `cpu_rd` = `mem_rd`, `stall`=0. Next state IDLE. No counters change and the line array is untouched.

Other rules:
- `cpu_rd` = 0 whenever no load completes this cycle.
- `cpu_req`=0: no memory write, `stall`=0, state unchanged (IDLE).
- Counters saturate at 0xFFFFFFFF.
- `flush`:
  - Clears all valid bits at the edge.
  - In REFILL it aborts the refill: no line written, next state IDLE, `stall` still 1 in that cycle.
  - In IDLE, a same-cycle access proceeds using the pre-flush valid bits.
- Reset clears:
  - state → IDLE
  - all valid bits → 0
  - `hit_count`, `miss_count` → 0
  - `stall`, `mem_we` → 0
  - `cpu_rd` → 0

## Timing
- Load hit: 0 stall cycles, data in the request cycle.
- Load miss: 2 stall cycles (IDLE-miss, REFILL). Data appears in cycle 3 as a hit.
- Misaligned word load: 1 stall cycle, data in BYPASS cycle.
- Store: 0 stall cycles. The `DataMemory` write lands at the end of the request cycle.
- Reset asserted mid-REFILL or mid-BYPASS: immediate return to IDLE, `stall`=0, nothing written.

## Structure
- Package `data_cache_pkg`:
  - state enum `cache_state_t` {IDLE, REFILL, BYPASS}
  - localparam functions for `INDEX_BITS` and `TAG_BITS`
  - counter width constant
- Sub-module `cache_line_array`:
  - valid/tag/data storage, async-reset valid bits, flush-clear
  - combinational read port
  - write port with byte-lane enables
- The FSM, address split, lane mux and counters live in `data_cache`.

## Test plan
Memory preload for all scenarios: bytes 0x10000..0x10004 = 11 22 33 44 55; `SETS`=8.

1. **Word load miss then hit.** After reset, word load at 0x10000 → `stall`=1 for 2 cycles, then `cpu_rd`=0x44332211, `miss_count`=1. Repeat the load → `stall`=0, `hit_count`=1.
2. **Byte load from cached line.** Byte load at 0x10002 → `cpu_rd`=0x00000033, no stall.
3. **Byte store hit.** Byte store 0xAA at 0x10001 → `mem_we`=1 that cycle. Next word load at 0x10000 hits with 0x4433AA11. A `DataMemory` backdoor read agrees.
4. **Conflict misses.** Loads at 0x10000, 0x10020, 0x10000 (same index, different tags) → three misses, `miss_count`=3.
5. **Misaligned word load.** Word load at 0x10001 → 1 stall cycle, `cpu_rd`=0x55443322, counters unchanged.
6. **Flush and reset during refill.**
   - `flush` in REFILL → IDLE with no line written; the held load misses again.
   - `rst` pulse mid-REFILL → `stall`=0 and counters 0 immediately.
